// File: rtl/payload_engine_pkg.sv
// payload_engine_pkg: scheduler state type and shared sizing helpers.
package payload_engine_pkg;
    typedef enum logic [2:0] {IDLE, ARM, STREAM, FLUSH, REPORT} sched_state_t;
    localparam int PIPE_LAT_DEFAULT = 2;
    function automatic int id_w(input int n);
        return $clog2(n);
    endfunction
endpackage

// File: rtl/payload_match_prienc.sv
// payload_match_prienc: lowest-set-bit encoder with any/exactly-one flags.
module payload_match_prienc #(
    parameter int N = 64,
    parameter int ID_W = 6
) (
    input  logic [N-1:0]    v,
    output logic [ID_W-1:0] id,
    output logic            any,
    output logic            single
);
    always_comb begin
        id = '0;
        for (int i = N - 1; i >= 0; i--) id = v[i] ? ID_W'(i) : id;
    end
    assign any = |v;
    assign single = any && ((v & (v - N'(1))) == '0);
endmodule

// File: rtl/payload_match_scheduler.sv
// payload_match_scheduler: per-packet engine sequencer and lowest-first match-ID reporter.
// Define PAYLOAD_MATCH_COUNT_EN to add the m_count and pkt_cnt outputs.
module payload_match_scheduler
    import payload_engine_pkg::*;
#(
    parameter int NUM_ENGINES = 64,
    parameter int ID_W = id_w(NUM_ENGINES),
    parameter int PIPE_LAT = PIPE_LAT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   s_sop,
    input  logic                   s_eop,
    output logic                   eng_sod,
    output logic                   eng_en,
    output logic                   eng_flush,
    input  logic [NUM_ENGINES-1:0] eng_match,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [ID_W-1:0]        m_id,
    output logic                   m_none,
    output logic                   m_last
`ifdef PAYLOAD_MATCH_COUNT_EN
    ,
    output logic [ID_W:0]          m_count,
    output logic [31:0]            pkt_cnt
`endif
);
    localparam int CW = $clog2(PIPE_LAT + 1);

    sched_state_t           state;
    logic [NUM_ENGINES-1:0] pending;
    logic [CW-1:0]          cnt;
    logic [ID_W-1:0]        low_id;
    logic                   any;
    logic                   single;
    logic                   snap;

    payload_match_prienc #(.N(NUM_ENGINES), .ID_W(ID_W)) u_prienc (
        .v(pending),
        .id(low_id),
        .any(any),
        .single(single)
    );

    // Stray beats outside a packet are consumed in IDLE so the stream cannot stall.
    assign s_ready = !rst && (state == STREAM || (state == IDLE && s_valid && !s_sop));
    assign eng_sod = rst || state == ARM;
    assign eng_en = !rst && (state == FLUSH || (state == STREAM && s_valid));
    assign eng_flush = !rst && state == FLUSH;
    assign m_valid = !rst && state == REPORT;
    assign m_id = m_valid ? low_id : '0;
    assign m_none = m_valid && !any;
    assign m_last = m_valid && (single || !any);
    assign snap = state == FLUSH && cnt == CW'(PIPE_LAT - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            pending <= '0;
        end else begin
            case (state)
                IDLE: state <= (s_valid && s_sop) ? ARM : IDLE;
                ARM: state <= STREAM;
                STREAM: if (s_valid && s_eop) begin
                    state <= FLUSH;
                    cnt <= '0;
                end
                FLUSH: if (snap) begin
                    state <= REPORT;
                    pending <= eng_match;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                REPORT: if (m_ready) begin
                    pending <= pending & ~(NUM_ENGINES'(1) << low_id);
                    state <= m_last ? IDLE : REPORT;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PAYLOAD_MATCH_COUNT_EN
    localparam int NW = ID_W + 1;
    logic [ID_W:0] snap_cnt;
    assign m_count = m_valid ? snap_cnt : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_cnt <= '0;
            pkt_cnt <= '0;
        end else begin
            if (snap) snap_cnt <= NW'($countones(eng_match));
            if (m_valid && m_ready && m_last && any) pkt_cnt <= pkt_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_payload_match_scheduler.sv
// tb_payload_match_scheduler: randomized packets checked against a packet-level match-report model.
module tb_payload_match_scheduler;
    localparam int N = 64;
    localparam int IW = 6;
    localparam int PL = 2;

    logic clk = 0;
    logic rst = 1;
    logic s_valid = 0;
    logic s_sop = 0;
    logic s_eop = 0;
    logic m_ready = 0;
    logic [N-1:0] eng_match = '0;
    logic s_ready, eng_sod, eng_en, eng_flush, m_valid, m_none, m_last;
    logic [IW-1:0] m_id;
`ifdef PAYLOAD_MATCH_COUNT_EN
    logic [IW:0] m_count;
    logic [31:0] pkt_cnt;
    int exp_pkt = 0;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    payload_match_scheduler #(.NUM_ENGINES(N), .ID_W(IW), .PIPE_LAT(PL)) dut (
        .clk(clk),
        .rst(rst),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_sop(s_sop),
        .s_eop(s_eop),
        .eng_sod(eng_sod),
        .eng_en(eng_en),
        .eng_flush(eng_flush),
        .eng_match(eng_match),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_id(m_id),
        .m_none(m_none),
        .m_last(m_last)
`ifdef PAYLOAD_MATCH_COUNT_EN
        ,
        .m_count(m_count),
        .pkt_cnt(pkt_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected report = ascending list of target bits; an empty list gives one m_none beat.
    task automatic run_pkt(input int nb, input logic [N-1:0] tgt, input bit early, input int stall0, input bit rnd);
        int q[$];
        int sent = 0;
        int cyc = 0;
        bit done = 0;
        for (int i = 0; i < N; i++) if (tgt[i]) q.push_back(i);
        eng_match = '0;
        s_valid = 1;
        s_sop = 1;
        s_eop = (nb == 1);
        @(negedge clk);
        chk("idle_ready", 64'(s_ready), 64'(0));
        chk("idle_sod", 64'(eng_sod), 64'(0));
        step();
        @(negedge clk);
        chk("arm_sod", 64'(eng_sod), 64'(1));
        chk("arm_ready", 64'(s_ready), 64'(0));
        chk("arm_en", 64'(eng_en), 64'(0));
        step();
        while (sent < nb) begin
            s_valid = (sent == 0) || ($urandom_range(3) != 0);
            s_sop = (sent == 0) || ($urandom_range(7) == 0);
            s_eop = (sent == nb - 1);
            if (early && s_valid && sent == nb / 2) eng_match = tgt & {32'h0, 32'hffffffff};
            @(negedge clk);
            chk("stream_ready", 64'(s_ready), 64'(1));
            chk("stream_en", 64'(eng_en), 64'(s_valid));
            chk("stream_sod", 64'(eng_sod), 64'(0));
            chk("stream_mvalid", 64'(m_valid), 64'(0));
            step();
            if (s_valid) sent++;
        end
        s_valid = 0;
        s_sop = 0;
        s_eop = 0;
        for (int k = 0; k < PL; k++) begin
            if (k == PL - 1) eng_match = tgt;
            @(negedge clk);
            chk("flush", 64'(eng_flush), 64'(1));
            chk("flush_en", 64'(eng_en), 64'(1));
            chk("flush_ready", 64'(s_ready), 64'(0));
            chk("flush_mvalid", 64'(m_valid), 64'(0));
            step();
        end
        eng_match = {$urandom, $urandom};
        while (!done) begin
            m_ready = (cyc < stall0) ? 1'b0 : (rnd && cyc < 200) ? 1'($urandom_range(1)) : 1'b1;
            @(negedge clk);
            chk("m_valid", 64'(m_valid), 64'(1));
            chk("m_id", 64'(m_id), 64'(q.size() != 0 ? q[0] : 0));
            chk("m_none", 64'(m_none), 64'(q.size() == 0));
            chk("m_last", 64'(m_last), 64'(q.size() <= 1));
`ifdef PAYLOAD_MATCH_COUNT_EN
            chk("m_count", 64'(m_count), 64'($countones(tgt)));
`endif
            step();
            cyc++;
            if (m_ready) begin
                if (q.size() <= 1) done = 1;
                else void'(q.pop_front());
            end
        end
        m_ready = 0;
        @(negedge clk);
        chk("post_mvalid", 64'(m_valid), 64'(0));
        chk("post_ready", 64'(s_ready), 64'(0));
`ifdef PAYLOAD_MATCH_COUNT_EN
        if (tgt != '0) exp_pkt++;
        chk("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
`endif
        step();
    endtask

    initial begin
        logic [N-1:0] tgt;
        step();
        @(negedge clk);
        chk("rst_sod", 64'(eng_sod), 64'(1));
        chk("rst_ready", 64'(s_ready), 64'(0));
        chk("rst_en", 64'(eng_en), 64'(0));
        chk("rst_flush", 64'(eng_flush), 64'(0));
        chk("rst_mvalid", 64'(m_valid), 64'(0));
        chk("rst_mnone", 64'(m_none), 64'(0));
        chk("rst_mlast", 64'(m_last), 64'(0));
        chk("rst_mid", 64'(m_id), 64'(0));
        step();
        rst = 0;
        run_pkt(8, (64'd1 << 5) | (64'd1 << 17), 0, 0, 0);
        run_pkt(5, '0, 0, 0, 0);
        run_pkt(3, 64'h8000_0000_0000_0001, 0, 4, 0);
        eng_match = '0;
        s_valid = 1;
        s_sop = 1;
        s_eop = 0;
        step();
        step();
        s_sop = 0;
        step();
        rst = 1;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            chk("midrst_sod", 64'(eng_sod), 64'(1));
            chk("midrst_ready", 64'(s_ready), 64'(0));
            chk("midrst_en", 64'(eng_en), 64'(0));
            step();
        end
        rst = 0;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            chk("drop_ready", 64'(s_ready), 64'(1));
            chk("drop_en", 64'(eng_en), 64'(0));
            chk("drop_sod", 64'(eng_sod), 64'(0));
            step();
        end
        s_valid = 0;
        run_pkt(6, 64'h0000_0F00_0000_0302, 1, 0, 1);
        run_pkt(1, 64'h0000_0100_0000_0040, 1, 0, 0);
        run_pkt(4, 64'h0000_0000_0000_0C00, 0, 1, 0);
        run_pkt(2, 64'h0000_0000_0100_0000, 0, 0, 1);
        for (int p = 0; p < 25; p++) begin
            case ($urandom_range(3))
                0: tgt = '0;
                1: tgt = 64'd1 << $urandom_range(63);
                2: tgt = (64'd1 << $urandom_range(63)) | (64'd1 << $urandom_range(63)) | (64'd1 << $urandom_range(63));
                default: tgt = {$urandom, $urandom};
            endcase
            run_pkt($urandom_range(10, 1), tgt, 1'($urandom_range(1)), $urandom_range(3), 1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
